// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake: req/addr from the fetch stage, ack/rdata back from memory.
interface if_stage_if #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         req;
    logic [PC_WIDTH-1:0]          addr;
    logic                         ack;
    logic [INSTRUCTION_WIDTH-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC, variable-latency imem fetch, redirects, stall buffer.
// Optional saturating perf counters when IF_PERF_COUNTERS_EN is defined.
//
// state     | meaning
// S_FETCH   | request outstanding at pc_q
// S_HOLD    | fetched word parked in buffer while decode is stalled, no request
// S_DISCARD | request outstanding but its data is stale; redir_q holds the real target
module if_stage #(
    parameter int                           PC_WIDTH          = 32,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_pipeline_i,
    input  logic                         is_jump_i,
    input  logic [PC_WIDTH-1:0]          jump_addr_i,
    input  logic                         branch_taken_i,
    input  logic [PC_WIDTH-1:0]          branch_addr_i,
    if_stage_if.master                   imem,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
    output logic [PC_WIDTH-1:0]          pc_o
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  perf_fetched_o,
    output logic [31:0]                  perf_bubbles_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [PC_WIDTH-1:0]            redir_q, redir_d;
    logic [INSTRUCTION_WIDTH-1:0]   buf_q, buf_d;
    logic [PC_WIDTH-1:0]            buf_pc_q, buf_pc_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]            pc_out_q, pc_out_d;

    logic                           redirect;
    logic [PC_WIDTH-1:0]            target;
    logic                           ack_fire;
    logic                           load_nop;
    logic                           load_word;

    assign redirect = branch_taken_i | is_jump_i;
    assign target   = branch_taken_i ? branch_addr_i : jump_addr_i;

    // Request is forced low during reset so an in-flight fetch is simply abandoned.
    assign imem.req  = rst && (state_q != S_HOLD);
    assign imem.addr = pc_q;
    assign ack_fire  = imem.req && imem.ack;

    assign instruction_o = instr_q;
    assign pc_o          = pc_out_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redir_d   = redir_q;
        buf_d     = buf_q;
        buf_pc_d  = buf_pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        load_nop  = 1'b0;
        load_word = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    instr_d  = NOP_WORD;
                    load_nop = 1'b1;
                    if (ack_fire) begin
                        pc_d = target;
                    end else begin
                        redir_d = target;
                        state_d = S_DISCARD;
                    end
                end else if (ack_fire) begin
                    pc_d = pc_q + 1'b1;
                    if (stall_pipeline_i) begin
                        buf_d    = imem.rdata;
                        buf_pc_d = pc_q;
                        state_d  = S_HOLD;
                    end else begin
                        instr_d   = imem.rdata;
                        pc_out_d  = pc_q;
                        load_word = 1'b1;
                    end
                end else if (!stall_pipeline_i) begin
                    instr_d  = NOP_WORD;
                    load_nop = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d     = target;
                    instr_d  = NOP_WORD;
                    load_nop = 1'b1;
                    state_d  = S_FETCH;
                end else if (!stall_pipeline_i) begin
                    instr_d   = buf_q;
                    pc_out_d  = buf_pc_q;
                    load_word = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_DISCARD: begin
                instr_d  = NOP_WORD;
                load_nop = 1'b1;
                // A redirect arriving with the ack is the newest target and wins over redir_q.
                if (ack_fire) begin
                    pc_d    = redirect ? target : redir_q;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    redir_d = target;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            redir_q  <= RESET_PC;
            buf_q    <= NOP_WORD;
            buf_pc_q <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (load_word && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (load_nop && (perf_bubbles_q != '1)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a behavioural fetch model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall, is_jump, branch_taken;
    logic [31:0] jump_addr, branch_addr;
    logic [31:0] instruction, pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) imem ();

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    if_stage #(
        .PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0), .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_pipeline_i(stall),
        .is_jump_i(is_jump),
        .jump_addr_i(jump_addr),
        .branch_taken_i(branch_taken),
        .branch_addr_i(branch_addr),
        .imem(imem),
        .instruction_o(instruction),
        .pc_o(pc)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_bubbles_o(perf_bubbles)
`endif
    );

    // Behavioural model: where the next fetch goes, whether a redirect is pending
    // behind an outstanding request, and whether a word is parked for a stalled decode.
    logic [31:0] m_fpc, m_redir_a, m_buf_w, m_buf_pc, m_instr, m_pc;
    bit          m_redir_v, m_buf_v;
    int unsigned m_fetched, m_bubbles;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd100;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = 32'h0; m_redir_a = 32'h0; m_buf_w = 32'h0; m_buf_pc = 32'h0;
        m_instr = NOP; m_pc = 32'h0; m_redir_v = 0; m_buf_v = 0;
        m_fetched = 0; m_bubbles = 0;
    endtask

    task automatic bubble();
        m_instr = NOP;
        m_bubbles++;
    endtask

    task automatic model_step(input bit st, input bit br, input logic [31:0] ba,
                              input bit jp, input logic [31:0] ja, input bit ak);
        bit          r;
        bit          done;
        logic [31:0] t;
        r    = br | jp;
        t    = br ? ba : ja;
        done = !m_buf_v && ak;
        if (m_buf_v) begin
            if (r) begin
                m_buf_v = 0; m_fpc = t; bubble();
            end else if (!st) begin
                m_instr = m_buf_w; m_pc = m_buf_pc; m_buf_v = 0; m_fetched++;
            end
        end else if (m_redir_v) begin
            bubble();
            if (r) m_redir_a = t;
            if (done) begin m_fpc = m_redir_a; m_redir_v = 0; end
        end else if (r) begin
            bubble();
            if (done) m_fpc = t;
            else begin m_redir_v = 1; m_redir_a = t; end
        end else if (done) begin
            if (st) begin
                m_buf_v = 1; m_buf_w = mem_word(m_fpc); m_buf_pc = m_fpc;
            end else begin
                m_instr = mem_word(m_fpc); m_pc = m_fpc; m_fetched++;
            end
            m_fpc = m_fpc + 32'd1;
        end else if (!st) begin
            bubble();
        end
    endtask

    // Starts and ends at a negedge: drive, sample req/addr, clock, sample instruction/pc.
    task automatic do_cycle(input bit st, input bit br, input logic [31:0] ba,
                            input bit jp, input logic [31:0] ja, input bit ak, input bit chk,
                            output logic o_req, output logic [31:0] o_addr,
                            output logic [31:0] o_instr, output logic [31:0] o_pc);
        stall = st; branch_taken = br; branch_addr = ba;
        is_jump = jp; jump_addr = ja;
        imem.ack = ak; imem.rdata = mem_word(imem.addr);
        #1;
        o_req = imem.req; o_addr = imem.addr;
        if (chk) begin
            check("imem_req", {31'b0, o_req}, {31'b0, !m_buf_v});
            if (!m_buf_v) check("imem_addr", o_addr, m_fpc);
        end
        @(posedge clk); #1;
        model_step(st, br, ba, jp, ja, ak);
        o_instr = instruction; o_pc = pc;
        if (chk) begin
            check("instruction", o_instr, m_instr);
            check("pc", o_pc, m_pc);
        end
        @(negedge clk);
    endtask

    logic        s_req;
    logic [31:0] s_addr, s_instr, s_pc;

    task automatic cyc(input bit st, input bit br, input logic [31:0] ba,
                       input bit jp, input logic [31:0] ja, input bit ak);
        do_cycle(st, br, ba, jp, ja, ak, 1'b1, s_req, s_addr, s_instr, s_pc);
    endtask

    // Reset asserted asynchronously mid-cycle, released on a negedge.
    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        stall = 0; is_jump = 0; branch_taken = 0; jump_addr = 0; branch_addr = 0;
        imem.ack = 0; imem.rdata = 0;
        #1;
        check("rst_req", {31'b0, imem.req}, 32'h0);
        check("rst_instruction", instruction, NOP);
        check("rst_pc", pc, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          st;
        bit          br;
        logic [31:0] ba;
        bit          jp;
        logic [31:0] ja;
        bit          ak;
        bit          e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit          seen;
        bit          st, br, jp, ak;
        logic [31:0] ba, ja;

        // st br ba jp ja ak | req addr instr pc
        vecs[0]  = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h0,        32'd100,     32'h0};
        vecs[1]  = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h1,        32'd101,     32'h1};
        vecs[2]  = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h2,        32'd102,     32'h2};
        vecs[3]  = '{1, 0, 32'h0,  0, 32'h0,        1, 1, 32'h3,        32'd102,     32'h2};
        vecs[4]  = '{1, 0, 32'h0,  0, 32'h0,        1, 0, 32'h4,        32'd102,     32'h2};
        vecs[5]  = '{0, 0, 32'h0,  0, 32'h0,        0, 0, 32'h4,        32'd103,     32'h3};
        vecs[6]  = '{0, 1, 32'h80, 1, 32'h20,       1, 1, 32'h4,        NOP,         32'h3};
        vecs[7]  = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h80,       32'd228,     32'h80};
        vecs[8]  = '{0, 0, 32'h0,  1, 32'hFFFFFFFF, 0, 1, 32'h81,       NOP,         32'h80};
        vecs[9]  = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h81,       NOP,         32'h80};
        vecs[10] = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'hFFFFFFFF, 32'd99,      32'hFFFFFFFF};
        vecs[11] = '{0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h0,        32'd100,     32'h0};
        vecs[12] = '{0, 0, 32'h0,  0, 32'h0,        0, 1, 32'h1,        NOP,         32'h0};
        vecs[13] = '{1, 0, 32'h0,  0, 32'h0,        0, 1, 32'h1,        NOP,         32'h0};

        stall = 0; is_jump = 0; branch_taken = 0; jump_addr = 0; branch_addr = 0;
        imem.ack = 0; imem.rdata = 0;
        model_reset();

        do_reset();
        for (int i = 0; i < 14; i++) begin
            do_cycle(vecs[i].st, vecs[i].br, vecs[i].ba, vecs[i].jp, vecs[i].ja, vecs[i].ak,
                     1'b0, s_req, s_addr, s_instr, s_pc);
            check($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_instr", i), s_instr, vecs[i].e_instr);
            check($sformatf("vec%0d_pc", i), s_pc, vecs[i].e_pc);
        end

        // Stall for four cycles with the word at address 5 parked.
        do_reset();
        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        check("stall_hold_instr", s_instr, 32'd104);
        check("stall_hold_pc", s_pc, 32'd4);
        cyc(0, 0, 0, 0, 0, 0);
        check("stall_release_instr", s_instr, 32'd105);
        check("stall_release_pc", s_pc, 32'd5);
        cyc(0, 0, 0, 0, 0, 1);
        check("stall_next_req", {31'b0, s_req}, 32'h1);
        check("stall_next_addr", s_addr, 32'd6);

        // Three-cycle memory latency.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
            check("lat_bubble", s_instr, NOP);
            cyc(0, 0, 0, 0, 0, 1);
            check("lat_word", s_instr, 32'(100 + k));
        end

        // Branch while a slow request to 0x10 is pending.
        do_reset();
        cyc(0, 0, 0, 1, 32'h10, 1);
        seen = 0;
        cyc(0, 0, 0, 0, 0, 0);
        check("disc_pending_addr", s_addr, 32'h10);
        cyc(0, 1, 32'h40, 0, 0, 0);
        if (s_instr == mem_word(32'h10)) seen = 1;
        cyc(0, 0, 0, 0, 0, 0);
        check("disc_addr_held", s_addr, 32'h10);
        if (s_instr == mem_word(32'h10)) seen = 1;
        cyc(0, 0, 0, 0, 0, 1);
        check("disc_nop", s_instr, NOP);
        if (s_instr == mem_word(32'h10)) seen = 1;
        check("disc_leak", {31'b0, seen}, 32'h0);
        cyc(0, 0, 0, 0, 0, 1);
        check("disc_next_addr", s_addr, 32'h40);

        // Reset asserted with a request outstanding, then randomized traffic.
        cyc(0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 15) == 0);
            jp = ($urandom_range(0, 15) == 0);
            ak = ($urandom_range(0, 1) == 0);
            ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            ja = $urandom_range(0, 255);
            cyc(st, br, ba, jp, ja, ak);
        end

`ifdef IF_PERF_COUNTERS_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_bubbles", perf_bubbles, m_bubbles);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the core_lapido pipeline; sits directly upstream of the decode stage and drives its `instruction` and `pc` inputs.
- Holds the word-addressed PC and fetches from instruction memory over a req/ack handshake that tolerates variable latency.
- Applies redirects: branch_taken from MEM, and jumps from ID.
- Handles pipeline stalls with a one-entry buffer, and inserts NOP bubbles when no instruction is available.

Parameters:
- PC_WIDTH, 32, width of the PC and of all addresses (word addressed, +1 per instruction).
- INSTRUCTION_WIDTH, 32, instruction word width.
- RESET_PC, 0, first fetch address after reset.
- NOP_WORD, 32'h0000_0000, bubble word driven to decode.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall_pipeline  in  1  from hazard unit; hold the PC and the decode-facing outputs.
- is_jump  in  1  from decode; unconditional redirect request.
- jump_addr  in  PC_WIDTH  jump target.
- branch_taken  in  1  from MEM; taken pc-relative branch.
- branch_addr  in  PC_WIDTH  branch target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_ack  in  1  read data valid, completes the current request.
- imem_rdata  in  INSTRUCTION_WIDTH  fetched word.
- instruction  out  INSTRUCTION_WIDTH  registered word to decode.
- pc  out  PC_WIDTH  registered address of `instruction`.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC, state=FETCH, buffer empty.
  - instruction=NOP_WORD, pc=RESET_PC.
  - imem_req=0 while rst=0.
  - First request is issued in the first cycle after release, with imem_addr=RESET_PC.
- Handshake:
  - A request completes in the cycle where imem_req=1 and imem_ack=1; a zero-wait ack in the same cycle is legal.
  - imem_addr is stable while imem_req=1 and ack is not yet seen.
  - imem_ack while imem_req=0 is ignored.
- Redirect:
  - redirect = branch_taken | is_jump.
  - Target is branch_addr if branch_taken, else jump_addr; branch has priority when both are asserted.
  - Redirect is acted on regardless of stall_pipeline.
- State FETCH (imem_req=1, imem_addr=pc_q):
  - Redirect with no ack: go to DISCARD and latch the target in redir_q. imem_addr holds until ack.
  - Redirect with ack: drop the data, pc_q=target, stay in FETCH.
  - Either redirect case: instruction<=NOP_WORD.
  - Ack, no stall: instruction<=imem_rdata, pc<=pc_q, pc_q<=pc_q+1.
  - Ack, stall: buffer<=imem_rdata, buf_pc<=pc_q, pc_q<=pc_q+1, go to HOLD. instruction/pc hold.
  - No ack, no stall: instruction<=NOP_WORD, pc holds.
  - No ack, stall: outputs hold.
- State HOLD (imem_req=0):
  - Redirect: discard the buffer, pc_q=target, go to FETCH, instruction<=NOP_WORD.
  - Stall still asserted: hold.
  - Stall released: instruction<=buffer, pc<=buf_pc, go to FETCH.
- State DISCARD (imem_req=1, imem_addr unchanged):
  - Ack: drop the data, pc_q=redir_q, go to FETCH.
  - Further redirect: overwrite redir_q with the newest target.
  - instruction=NOP_WORD throughout.
- PC arithmetic: pc_q+1 wraps modulo 2^PC_WIDTH; the all-ones address is followed by 0.
- Latency: a request acked in cycle N appears on `instruction` after posedge N+1, absent stall or redirect.
- Throughput: one instruction per cycle with zero-wait memory.
- Reset mid-request: the outstanding request is abandoned; the memory is required to tolerate a dropped request.

Optional Feature:
- Macro: IF_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_bubbles (32 bits), both saturating and both cleared by rst.
  - perf_fetched increments on every ack delivered to `instruction`, directly or via the buffer.
  - perf_bubbles increments on every cycle NOP_WORD is loaded into `instruction`.
- Undefined: these ports and the counter logic are absent; fetch behaviour is identical.

Test Plan:
- Reset released with zero-wait memory returning word=addr+100 → imem_addr 0,1,2…; instruction 100,101,… each cycle; pc 0,1,2,… one cycle behind.
- Memory with 3-cycle ack latency → imem_addr held 3 cycles per request; two NOP_WORD bubbles between valid instructions.
- Ack at pc_q=5 while stall_pipeline=1 for 4 cycles → instruction/pc unchanged; one cycle after stall drops, word@5 appears with pc=5, then the request at 6 issues.
- branch_taken=1 with branch_addr=0x40 while a 3-cycle request to 0x10 is pending → DISCARD; word@0x10 never reaches instruction; next imem_addr=0x40; NOP_WORD meanwhile.
- branch_taken=1 (0x80) and is_jump=1 (0x20) in the same cycle → next fetch at 0x80; then pc_q=32'hFFFF_FFFF fetch is followed by 0x0.
